// File: rtl/hmac_stream_packer_pkg.sv
// Shared sizes and FSM state encoding for the HMAC stream packer.
package hmac_pkg;

  localparam int KEY_BITS   = 512;
  localparam int HASH_BITS  = 256;
  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_READY,
    PACK,
    FLUSH,
    FINAL,
    WAIT_HASH
  } state_t;

endpackage

// File: rtl/hmac_stream_packer_if.sv
// Byte stream, key load, HMAC core control/status and tag result bundle.
interface hmac_stream_packer_if #(
  parameter int LEN_WIDTH = 16
);

  logic                                in_valid;
  logic [7:0]                          in_data;
  logic                                in_last;
  logic                                in_ready;
  logic [hmac_pkg::KEY_BITS-1:0]       key_in;
  logic                                key_load;
  logic                                hmac_start;
  logic                                hmac_key_update;
  logic                                hmac_update;
  logic                                hmac_finalize;
  logic [hmac_pkg::KEY_BITS-1:0]       hmac_key;
  logic [8*hmac_pkg::WORD_BYTES-1:0]   hmac_data;
  logic [2:0]                          hmac_bytes_valid;
  logic                                hmac_ready;
  logic                                hmac_hash_valid;
  logic [hmac_pkg::HASH_BITS-1:0]      hmac_hash;
  logic                                tag_valid;
  logic [hmac_pkg::HASH_BITS-1:0]      tag;
  logic [LEN_WIDTH-1:0]                tag_len;
  logic                                len_overflow;

  // The master side is the message source plus the HMAC core.
  modport master (
    output in_valid, in_data, in_last, key_in, key_load,
    output hmac_ready, hmac_hash_valid, hmac_hash,
    input  in_ready, hmac_start, hmac_key_update, hmac_update, hmac_finalize,
    input  hmac_key, hmac_data, hmac_bytes_valid,
    input  tag_valid, tag, tag_len, len_overflow
  );

  modport slave (
    input  in_valid, in_data, in_last, key_in, key_load,
    input  hmac_ready, hmac_hash_valid, hmac_hash,
    output in_ready, hmac_start, hmac_key_update, hmac_update, hmac_finalize,
    output hmac_key, hmac_data, hmac_bytes_valid,
    output tag_valid, tag, tag_len, len_overflow
  );

endinterface

// File: rtl/hmac_stream_packer_word_packer.sv
// Packs accepted bytes big-endian into core words and emits one update
// pulse per full word, or per partial word when the message ends.
module hmac_word_packer
  import hmac_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_clear,
  input  logic                      i_accept,
  input  logic [7:0]                i_byte,
  input  logic                      i_last,
  output logic                      o_update,
  output logic [8*WORD_BYTES-1:0]   o_data,
  output logic [2:0]                o_bytesValid
);

  logic [8*WORD_BYTES-1:0] r_acc;
  logic [8*WORD_BYTES-1:0] r_data;
  logic [1:0]              r_cnt;
  logic                    r_update;
  logic [2:0]              r_bv;
  logic [8*WORD_BYTES-1:0] w_merged;
  logic                    w_wordDone;

  // New byte lands in the slot after the ones already held; slots past the
  // end of a short final word stay zero because r_acc starts cleared.
  always_comb begin
    w_merged   = r_acc | ({i_byte, {(8*WORD_BYTES-8){1'b0}}} >> {r_cnt, 3'b000});
    w_wordDone = i_last || (r_cnt == 2'd3);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_update <= 1'b0;
      r_data   <= '0;
      r_bv     <= '0;
    end else begin
      r_update <= 1'b0;
      r_data   <= '0;
      r_bv     <= '0;
      if (i_clear) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (i_accept) begin
        if (w_wordDone) begin
          r_update <= 1'b1;
          r_data   <= w_merged;
          r_bv     <= {1'b0, r_cnt} + 3'd1;
          r_acc    <= '0;
          r_cnt    <= '0;
        end else begin
          r_acc <= w_merged;
          r_cnt <= r_cnt + 2'd1;
        end
      end
    end
  end

  assign o_update     = r_update;
  assign o_data       = r_data;
  assign o_bytesValid = r_bv;

endmodule

// File: rtl/hmac_stream_packer.sv
// Streams message bytes into an HMAC core: sequences start/update/finalize,
// manages the pending key and captures the resulting tag.
module hmac_stream_packer
  import hmac_pkg::*;
#(
  parameter int LEN_WIDTH = 16
) (
  input logic                 clk,
  input logic                 rst,
  hmac_stream_packer_if.slave bus
);

  state_t                  r_state;
  logic [KEY_BITS-1:0]     r_pendingKey;
  logic [KEY_BITS-1:0]     r_hmacKey;
  logic                    r_keyDirty;
  logic                    r_keyUpdate;
  logic                    r_inReady;
  logic                    r_start;
  logic                    r_finalize;
  logic                    r_tagValid;
  logic                    r_lenOverflow;
  logic [HASH_BITS-1:0]    r_tag;
  logic [LEN_WIDTH-1:0]    r_len;
  logic [LEN_WIDTH-1:0]    r_tagLen;
  logic                    w_accept;
  logic                    w_goStart;
  logic                    w_dirtyNext;
  logic [KEY_BITS-1:0]     w_keyNext;
  logic                    w_update;
  logic [8*WORD_BYTES-1:0] w_data;
  logic [2:0]              w_bv;

  // A key strobe in the same cycle that launches START is folded straight in.
  always_comb begin
    w_accept    = r_inReady && bus.in_valid;
    w_goStart   = (r_state == IDLE) && bus.in_valid;
    w_keyNext   = bus.key_load ? bus.key_in : r_pendingKey;
    w_dirtyNext = bus.key_load || r_keyDirty;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pendingKey <= '0;
      r_hmacKey    <= '0;
      r_keyDirty   <= 1'b1;
      r_keyUpdate  <= 1'b0;
    end else begin
      r_pendingKey <= w_keyNext;
      r_keyUpdate  <= w_goStart && w_dirtyNext;
      if (w_goStart) begin
        r_hmacKey  <= w_keyNext;
        r_keyDirty <= 1'b0;
      end else begin
        r_keyDirty <= w_dirtyNext;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_inReady     <= 1'b0;
      r_start       <= 1'b0;
      r_finalize    <= 1'b0;
      r_tagValid    <= 1'b0;
      r_tag         <= '0;
      r_tagLen      <= '0;
      r_len         <= '0;
      r_lenOverflow <= 1'b0;
    end else begin
      r_start    <= 1'b0;
      r_finalize <= 1'b0;
      r_tagValid <= 1'b0;
      if (w_accept) begin
        if (r_len == '1) r_lenOverflow <= 1'b1;
        else             r_len         <= r_len + LEN_WIDTH'(1);
      end
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_state       <= START;
            r_start       <= 1'b1;
            r_len         <= '0;
            r_lenOverflow <= 1'b0;
          end
        end
        START: r_state <= WAIT_READY;
        WAIT_READY: begin
          if (bus.hmac_ready) begin
            r_state   <= PACK;
            r_inReady <= 1'b1;
          end
        end
        // The packer issues the closing update during FLUSH; finalize follows it.
        PACK: begin
          if (w_accept && bus.in_last) begin
            r_state   <= FLUSH;
            r_inReady <= 1'b0;
          end
        end
        FLUSH: begin
          r_state    <= FINAL;
          r_finalize <= 1'b1;
        end
        FINAL: r_state <= WAIT_HASH;
        WAIT_HASH: begin
          if (bus.hmac_hash_valid) begin
            r_state    <= IDLE;
            r_tag      <= bus.hmac_hash;
            r_tagLen   <= r_len;
            r_tagValid <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  hmac_word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_goStart),
    .i_accept     (w_accept),
    .i_byte       (bus.in_data),
    .i_last       (bus.in_last),
    .o_update     (w_update),
    .o_data       (w_data),
    .o_bytesValid (w_bv)
  );

  assign bus.in_ready         = r_inReady;
  assign bus.hmac_start       = r_start;
  assign bus.hmac_key_update  = r_keyUpdate;
  assign bus.hmac_update      = w_update;
  assign bus.hmac_finalize    = r_finalize;
  assign bus.hmac_key         = r_hmacKey;
  assign bus.hmac_data        = w_data;
  assign bus.hmac_bytes_valid = w_bv;
  assign bus.tag_valid        = r_tagValid;
  assign bus.tag              = r_tag;
  assign bus.tag_len          = r_tagLen;
  assign bus.len_overflow     = r_lenOverflow;

endmodule

// File: tb/tb_hmac_stream_packer.sv
// Table-driven bench for hmac_stream_packer with a behavioural HMAC core
// and a scoreboard of expected update words.
module tb_hmac_stream_packer;
  import hmac_pkg::*;

  localparam int LW   = 5;
  localparam int MAXB = 40;
  localparam int NVEC = 8;

  typedef struct {
    logic [8*MAXB-1:0]    msg;
    int                   len;
    logic [KEY_BITS-1:0]  key;
    int                   keyAt;
    int                   readyDelay;
    logic [HASH_BITS-1:0] hash;
    int                   expWords;
    int                   expLen;
    logic                 expOvf;
  } vec_t;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  bv;
  } upd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hmac_stream_packer_if #(.LEN_WIDTH(LW)) bif ();

  hmac_stream_packer #(.LEN_WIDTH(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  upd_t                 expQ[$];
  vec_t                 vecs[NVEC];
  int                   nCompare = 0;
  int                   nFail = 0;
  logic [KEY_BITS-1:0]  tbPending = '0;
  logic [KEY_BITS-1:0]  startKey = '0;
  logic                 tbDirty = 1'b1;
  logic [HASH_BITS-1:0] curHash = '0;
  logic [HASH_BITS-1:0] lastTag = '0;
  int                   curLen = 0;
  logic                 curOvf = 1'b0;
  int                   readyDelay = 0;
  int                   readyCnt = 0;
  int                   hashCnt = 0;
  int                   updCount = 0;
  int                   tagSeen = 0;
  int                   lowReadyIn = 0;
  logic                 prevUpdate = 1'b0;
  logic                 prevTagValid = 1'b0;

  task automatic checkOutput(input string name, input logic [KEY_BITS-1:0] actual,
                             input logic [KEY_BITS-1:0] expected);
    nCompare++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  task automatic checkIdleOutputs();
    checkOutput("idle_in_ready", bif.in_ready, 1'b0);
    checkOutput("idle_pulses", {bif.hmac_start, bif.hmac_key_update, bif.hmac_update,
                                bif.hmac_finalize, bif.tag_valid}, 5'b0);
    checkOutput("idle_hmac_key", bif.hmac_key, '0);
    checkOutput("idle_data_bv", {bif.hmac_data, bif.hmac_bytes_valid}, '0);
    checkOutput("idle_tag", bif.tag, '0);
    checkOutput("idle_tag_len_ovf", {bif.tag_len, bif.len_overflow}, '0);
  endtask

  // Behavioural core: drives ready/hash and checks every pulse it receives.
  task automatic coreModel();
    upd_t e;
    bif.hmac_ready      = 1'b1;
    bif.hmac_hash_valid = 1'b0;
    bif.hmac_hash       = '0;
    forever begin
      @(negedge clk);
      bif.hmac_hash_valid = 1'b0;
      if (rst) begin
        readyCnt       = 0;
        hashCnt        = 0;
        bif.hmac_ready = 1'b1;
      end
      if (readyCnt > 0) begin
        readyCnt--;
        if (readyCnt == 0) bif.hmac_ready = 1'b1;
      end
      if (!bif.hmac_ready && bif.in_ready) lowReadyIn++;
      if (bif.hmac_start || bif.hmac_update || bif.hmac_finalize)
        checkOutput("pulse_exclusive", int'(bif.hmac_start) + int'(bif.hmac_update) +
                    int'(bif.hmac_finalize), 1);
      if (bif.hmac_key_update) checkOutput("key_update_with_start", bif.hmac_start, 1'b1);
      if (bif.hmac_start) begin
        checkOutput("key_update", bif.hmac_key_update, tbDirty);
        checkOutput("hmac_key", bif.hmac_key, tbPending);
        tbDirty  = 1'b0;
        startKey = tbPending;
        if (readyDelay > 0) begin
          bif.hmac_ready = 1'b0;
          readyCnt       = readyDelay;
        end
      end
      if (bif.hmac_update) begin
        updCount++;
        checkOutput("update_expected", expQ.size() > 0, 1'b1);
        if (expQ.size() > 0) begin
          e = expQ.pop_front();
          checkOutput("hmac_data", bif.hmac_data, e.data);
          checkOutput("bytes_valid", bif.hmac_bytes_valid, e.bv);
        end
      end
      if (bif.hmac_finalize) begin
        checkOutput("finalize_after_update", prevUpdate, 1'b1);
        checkOutput("pending_updates", expQ.size(), 0);
        checkOutput("key_held", bif.hmac_key, startKey);
        hashCnt = 2;
      end else if (hashCnt > 0) begin
        hashCnt--;
        if (hashCnt == 0) begin
          bif.hmac_hash       = curHash;
          bif.hmac_hash_valid = 1'b1;
        end
      end
      if (bif.tag_valid) begin
        checkOutput("tag_pulse", prevTagValid, 1'b0);
        checkOutput("tag", bif.tag, curHash);
        checkOutput("tag_len", bif.tag_len, curLen);
        checkOutput("len_overflow", bif.len_overflow, curOvf);
        lastTag = curHash;
        tagSeen++;
      end
      prevUpdate   = bif.hmac_update;
      prevTagValid = bif.tag_valid;
    end
  endtask

  // Sends one message; abortAt < len stops after that many accepted bytes.
  task automatic applyStimulus(input vec_t v, input int abortAt);
    upd_t e;
    int   i;
    int   cyc;
    int   t0;
    logic kdone;
    checkOutput("tag_held", bif.tag, lastTag);
    for (int w = 0; w * 4 < v.len; w++) begin
      e.data = '0;
      for (int b = 0; b < 4; b++)
        if (w * 4 + b < v.len) e.data[31-8*b -: 8] = v.msg[8*MAXB-1-8*(w*4+b) -: 8];
      e.bv = 3'((v.len - w * 4) > 4 ? 4 : (v.len - w * 4));
      expQ.push_back(e);
    end
    curHash    = v.hash;
    curLen     = v.expLen;
    curOvf     = v.expOvf;
    readyDelay = v.readyDelay;
    updCount   = 0;
    lowReadyIn = 0;
    t0         = tagSeen;
    kdone      = 1'b0;
    i          = 0;
    cyc        = 0;
    while (i < v.len && i != abortAt && cyc < 400) begin
      @(negedge clk);
      bif.key_load = 1'b0;
      if (!kdone && i == v.keyAt) begin
        bif.key_load = 1'b1;
        bif.key_in   = v.key;
        tbPending    = v.key;
        tbDirty      = 1'b1;
        kdone        = 1'b1;
      end
      bif.in_valid = 1'b1;
      bif.in_data  = v.msg[8*MAXB-1-8*i -: 8];
      bif.in_last  = (i == v.len - 1);
      if (bif.in_ready) i++;
      cyc++;
    end
    @(negedge clk);
    bif.in_valid = 1'b0;
    bif.in_last  = 1'b0;
    bif.key_load = 1'b0;
    if (cyc >= 400) checkOutput("byte_accept_timeout", i, v.len);
    if (abortAt >= v.len) begin
      cyc = 0;
      while (tagSeen == t0 && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      checkOutput("tag_seen", tagSeen - t0, 1);
      checkOutput("update_count", updCount, v.expWords);
      if (v.readyDelay > 0) checkOutput("in_ready_while_core_busy", lowReadyIn, 0);
      @(negedge clk);
    end
  endtask

  initial begin : stimulus
    vec_t abortVec;
    logic [KEY_BITS-1:0] keyB;
    keyB = {8{64'h0123456789abcdef}};

    vecs[0] = '{msg: {"Hi There", 256'b0}, len: 8, key: {{20{8'h0b}}, 352'b0}, keyAt: 0,
                readyDelay: 0,
                hash: 256'hb0344c61d8db38535ca8afceaf0bf12b881dc200c9833da726e9376c2e32cff7,
                expWords: 2, expLen: 8, expOvf: 1'b0};
    vecs[1] = '{msg: {"what do ya want for nothing?", 96'b0}, len: 28, key: {"Jefe", 480'b0},
                keyAt: 0, readyDelay: 0,
                hash: 256'h5bdcc146bf60754e6a042426089575c75a003f089d2739839dec58b964ec3843,
                expWords: 7, expLen: 28, expOvf: 1'b0};
    vecs[2] = '{msg: {"abcde", 280'b0}, len: 5, key: '0, keyAt: -1, readyDelay: 0,
                hash: {8{32'h1234abcd}}, expWords: 2, expLen: 5, expOvf: 1'b0};
    vecs[3] = '{msg: {"a", 312'b0}, len: 1, key: '0, keyAt: -1, readyDelay: 0,
                hash: {8{32'h0badf00d}}, expWords: 1, expLen: 1, expOvf: 1'b0};
    vecs[4] = '{msg: {"0123456789", 240'b0}, len: 10, key: '0, keyAt: -1, readyDelay: 10,
                hash: {8{32'hcafe0004}}, expWords: 3, expLen: 10, expOvf: 1'b0};
    vecs[5] = '{msg: '0, len: 35, key: '0, keyAt: -1, readyDelay: 0,
                hash: {8{32'h5a5a0005}}, expWords: 9, expLen: 31, expOvf: 1'b1};
    for (int k = 0; k < 35; k++) vecs[5].msg[8*MAXB-1-8*k -: 8] = 8'(k * 7 + 3);
    vecs[6] = '{msg: {"hello world!", 224'b0}, len: 12, key: keyB, keyAt: 2, readyDelay: 0,
                hash: {8{32'h77770006}}, expWords: 3, expLen: 12, expOvf: 1'b0};
    vecs[7] = '{msg: {"wxyz", 288'b0}, len: 4, key: '0, keyAt: -1, readyDelay: 0,
                hash: {8{32'h88880007}}, expWords: 1, expLen: 4, expOvf: 1'b0};
    abortVec = '{msg: {"ABCDEF", 272'b0}, len: 6, key: '0, keyAt: -1, readyDelay: 0,
                 hash: {8{32'hdead0008}}, expWords: 2, expLen: 6, expOvf: 1'b0};

    bif.in_valid = 1'b0;
    bif.in_data  = '0;
    bif.in_last  = 1'b0;
    bif.key_in   = '0;
    bif.key_load = 1'b0;
    fork
      coreModel();
      begin
        #100000;
        nFail++;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $display("== %0d vectors applied, %0d miscompares ==", nCompare, nFail);
        $finish;
      end
    join_none

    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkIdleOutputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int n = 0; n < NVEC; n++) applyStimulus(vecs[n], vecs[n].len);

    // Asynchronous reset with three bytes packed, then a clean message.
    applyStimulus(abortVec, 3);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 checkIdleOutputs();
    expQ.delete();
    tbDirty   = 1'b1;
    tbPending = '0;
    startKey  = '0;
    lastTag   = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    applyStimulus(vecs[0], vecs[0].len);

    $display("== %0d vectors applied, %0d miscompares ==", nCompare, nFail);
    $finish;
  end

endmodule

// File: doc/hmac_stream_packer.md
HMAC_STREAM_PACKER -- requirements
Module: hmac_stream_packer

Interface
REQ-001 Parameter: LEN_WIDTH, 16, width of the message byte counter.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-003 clk  in  1  sole clock, all logic on rising edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 in_valid  in  1  upstream byte present.
REQ-006 in_data  in  8  message byte.
REQ-007 in_last  in  1  byte is final byte of message.
REQ-008 in_ready  out  1  byte accepted when in_valid && in_ready.
REQ-009 key_in  in  512  HMAC key, left-justified, zero-padded.
REQ-010 key_load  in  1  one-cycle strobe capturing key_in into the pending-key register.
REQ-011 hmac_start, hmac_key_update, hmac_update, hmac_finalize  out  1 each  core control pulses.
REQ-012 hmac_key  out  512 / hmac_data  out  32 / hmac_bytes_valid  out  3  core data.
REQ-013 hmac_ready  in  1 / hmac_hash_valid  in  1 / hmac_hash  in  256  core status.
REQ-014 tag_valid  out  1  one-cycle pulse; tag  out  256 / tag_len  out  LEN_WIDTH / len_overflow  out  1.

Function
REQ-015 States SHALL be IDLE, START, WAIT_READY, PACK, FLUSH, FINAL, WAIT_HASH.
REQ-016 IDLE: in_ready=0; in_valid=1 -> START.
REQ-017 START (1 cycle): hmac_start=1, hmac_key_update=key_dirty, hmac_key loaded from pending key, key_dirty cleared -> WAIT_READY.
REQ-018 WAIT_READY: in_ready=0 until hmac_ready=1 -> PACK.
REQ-019 PACK: in_ready=1; bytes packed big-endian, first byte in hmac_data[31:24].
REQ-020 Acceptance of 4th byte of a word SHALL produce hmac_update=1 with bytes_valid=4 on the next cycle; next byte acceptable that same cycle (no bubble).
REQ-021 Acceptance of in_last SHALL -> FLUSH: one hmac_update carrying remaining 1..4 bytes, bytes_valid = count, unused low bytes zero.
REQ-022 FLUSH -> FINAL: hmac_finalize=1 exactly one cycle after the last hmac_update -> WAIT_HASH.
REQ-023 WAIT_HASH: on hmac_hash_valid, tag<=hmac_hash, tag_valid=1 for one cycle, -> IDLE; tag held until next capture.
REQ-024 hmac_start/update/finalize/key_update SHALL be single-cycle pulses, never asserted together.
REQ-025 Byte counter increments per accepted byte, saturates at 2^LEN_WIDTH-1 and sets len_overflow; both cleared at START; tag_len valid with tag_valid.
REQ-026 key_load in any state SHALL update pending key and set key_dirty; in-flight message keeps its key.
REQ-027 key_load in the IDLE cycle that triggers START SHALL be used by that START.
REQ-028 Empty messages unsupported; in_last on first byte = 1-byte message.

Reset
REQ-029 rst SHALL force IDLE; all outputs 0; tag, tag_len, key registers 0; key_dirty=1.
REQ-030 rst mid-message SHALL discard packed bytes and counter; no finalize issued; next START reinitialises the core.

Structure
REQ-031 Package hmac_pkg SHALL hold state enum, KEY_BITS=512, HASH_BITS=256, WORD_BYTES=4.
REQ-032 Byte-to-word accumulation SHALL live in sub-module hmac_word_packer; FSM and key/tag registers in top.

Verification
REQ-033 Key 20x0b, "Hi There" -> updates 0x48692054/bv4, 0x68657265/bv4, finalize, tag b0344c61d8db38535ca8afceaf0bf12b881dc200c9833da726e9376c2e32cff7, tag_len=8.
REQ-034 Key "Jefe", "what do ya want for nothing?" -> 7 updates bv4, tag 5bdcc146bf60754e6a042426089575c75a003f089d2739839dec58b964ec3843.
REQ-035 Message 0x61 0x62 0x63 0x64 0x65 -> update 0x61626364/bv4 then 0x65000000/bv1, finalize next cycle; single byte 0x61 -> 0x61000000/bv1.
REQ-036 hmac_ready held low 10 cycles after start -> in_ready low those cycles, no bytes lost.
REQ-037 key_load mid-PACK -> current tag uses old key; next message asserts hmac_key_update with new key.
REQ-038 rst during PACK after 3 bytes -> all outputs 0 asynchronously; subsequent message produces correct tag.
